// File: rtl/reset_seq_multi.sv
// reset_seq_multi: a single reset sequencer for every reset domain on a board top.
// It synchronizes and debounces an active-low reset button and synchronizes N PLL
// lock flags. The M active-high reset outputs are released in index order, one
// every STAGE_DELAY_CYCLES. All outputs are re-asserted together when a lock drops,
// when the button is pressed, or when a soft request arrives.
//
// soft_reset_req is a one-cycle pulse with no acknowledge. Its effect is visible
// on reset_out/state_dbg on the following cycle.
//
// While the debounced button is held pressed, the sequencer is pinned in HOLD and
// its counters are held at zero. As a result, the minimum HOLD time is always
// measured from the debounced release.
module reset_seq_multi #(
  parameter int NUM_OUTPUTS        = 3,
  parameter int NUM_LOCKS          = 2,
  parameter int DEBOUNCE_CYCLES    = 8,
  parameter int HOLD_MIN_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES = 32,
  parameter int STAGE_DELAY_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   button_n,
  input  logic [NUM_LOCKS-1:0]   lock_in,
  input  logic                   soft_reset_req,
  output logic [NUM_OUTPUTS-1:0] reset_out,
  output logic                   ready,
  output logic [1:0]             state_dbg
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLD_MIN_CYCLES + 1);
  localparam int LOCK_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int STAGE_W = $clog2(STAGE_DELAY_CYCLES + 1);
  localparam int IDX_W   = $clog2(NUM_OUTPUTS + 1);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_MIN_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Synchronizers and debouncer
  logic                 btn_s1_q, btn_s2_q;
  logic [NUM_LOCKS-1:0] lock_s1_q, lock_s2_q;
  logic                 db_q, db_d;     // debounced button, 1 = released
  logic [DB_W-1:0]      dbc_q, dbc_d;

  // Sequencer
  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [STAGE_W-1:0]   stage_cnt_q, stage_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] reset_out_q, reset_out_d;
  logic                 ready_q, ready_d;

  logic locked;
  logic pressed;

  assign locked  = &lock_s2_q;
  assign pressed = ~db_q;

  // Two-flop synchronizers for the button and lock inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      lock_s1_q <= '0;
      lock_s2_q <= '0;
    end else begin
      btn_s1_q  <= button_n;
      btn_s2_q  <= btn_s1_q;
      lock_s1_q <= lock_in;
      lock_s2_q <= lock_s1_q;
    end
  end

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    db_d  = db_q;
    dbc_d = dbc_q;
    if (btn_s2_q == db_q) begin
      dbc_d = '0;
    end else if (dbc_q == DB_LAST) begin
      db_d  = btn_s2_q;
      dbc_d = '0;
    end else begin
      dbc_d = dbc_q + 1'b1;
    end
  end

  // Debounce state register
  always_ff @(posedge clock) begin
    if (reset) begin
      db_q  <= 1'b1;
      dbc_q <= '0;
    end else begin
      db_q  <= db_d;
      dbc_q <= dbc_d;
    end
  end

  // Sequencer next-state: press/soft request > lock loss > normal progress
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    stage_cnt_d = stage_cnt_q;
    idx_d       = idx_q;
    reset_out_d = reset_out_q;

    if (pressed || soft_reset_req) begin
      state_d     = S_HOLD;
      hold_cnt_d  = '0;
      lock_cnt_d  = '0;
      stage_cnt_d = '0;
      idx_d       = '0;
      reset_out_d = '1;
    end else begin
      case (state_q)
        S_HOLD: begin
          reset_out_d = '1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = S_WAIT_LOCK;
            lock_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          reset_out_d = '1;
          if (!locked) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_d     = S_RELEASE;
            lock_cnt_d  = '0;
            stage_cnt_d = '0;
            idx_d       = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!locked) begin
            state_d     = S_WAIT_LOCK;
            lock_cnt_d  = '0;
            stage_cnt_d = '0;
            idx_d       = '0;
            reset_out_d = '1;
          end else if (stage_cnt_q == STAGE_LAST) begin
            stage_cnt_d = '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
              if (idx_q == IDX_W'(k)) reset_out_d[k] = 1'b0;
            end
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked) begin
            state_d     = S_WAIT_LOCK;
            lock_cnt_d  = '0;
            reset_out_d = '1;
          end else begin
            reset_out_d = '0;
          end
        end
        default: begin
          state_d     = S_HOLD;
          reset_out_d = '1;
        end
      endcase
    end

    // ready is high only for cycles spent in RUN that are not being left
    ready_d = (state_q == S_RUN) && (state_d == S_RUN);
  end

  // Sequencer state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      stage_cnt_q <= '0;
      idx_q       <= '0;
      reset_out_q <= '1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      idx_q       <= idx_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
    end
  end

  assign reset_out = reset_out_q;
  assign ready     = ready_q;
  assign state_dbg = state_q;

endmodule
